u_mask_scan: RTL and testbench

//   Sequential, run-time-configurable successor to the fixed-pivot mask

---
 rtl/u_mask_scan_if.sv | 29 ++
 rtl/u_mask_scan.sv | 134 +++++++++++++
 tb/tb_u_mask_scan.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/u_mask_scan_if.sv
// Request/result handshake bundle for the chunked mask scanner.
interface u_mask_scan_if #(
  parameter int unsigned W = 64
) ();
  localparam int unsigned PW = $clog2(W);

  logic          i_vld;
  logic          o_rdy;
  logic [W-1:0]  i_x;
  logic [PW-1:0] i_pivot;
  logic          i_bit;
  logic          i_lsb;
  logic          i_kill;
  logic          o_vld;
  logic          i_rdy;
  logic          o_all;
  logic [PW-1:0] o_pos;
  logic          o_busy;

  modport slave (
    input  i_vld, i_x, i_pivot, i_bit, i_lsb, i_kill, i_rdy,
    output o_rdy, o_vld, o_all, o_pos, o_busy
  );

  modport master (
    output i_vld, i_x, i_pivot, i_bit, i_lsb, i_kill, i_rdy,
    input  o_rdy, o_vld, o_all, o_pos, o_busy
  );
endinterface

// File: rtl/u_mask_scan.sv
// Sequential mask scanner: walks outward from a run-time pivot CHUNK_W bits
// per cycle and reports all-match or the mismatch nearest the pivot.
module u_mask_scan #(
  parameter int unsigned W       = 64,
  parameter int unsigned CHUNK_W = 16
) (
  input  logic         clk,
  input  logic         arst,
  u_mask_scan_if.slave bus
);
  localparam int unsigned PW     = $clog2(W);
  localparam int unsigned NCHUNK = W / CHUNK_W;
  localparam int unsigned CPW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (W % CHUNK_W != 0) begin : g_bad_chunk
    $error("u_mask_scan: W must be a multiple of CHUNK_W");
  end

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    x_r;
  logic [PW-1:0]   piv_r;
  logic            bit_r;
  logic            lsb_r;
  logic [CPW-1:0]  c_r;

  logic [PW-1:0]      piv_in;
  logic [CHUNK_W-1:0] chunk;
  logic [CHUNK_W-1:0] exam;
  logic [CHUNK_W-1:0] mm;
  logic [CPW-1:0]     piv_c;
  int unsigned        off;
  int unsigned        hit_j;
  logic [PW-1:0]      hit_pos;
  logic               hit_any;
  logic               last_c;
  logic               accept;

  // Kill wins over a same-cycle handshake, so ready drops with it in DONE.
  assign bus.o_rdy = !arst && ((state == IDLE) ||
                     (state == DONE && bus.i_rdy && !bus.i_kill));
  assign accept    = bus.i_vld && bus.o_rdy;

  // Current-chunk evaluation: mask the far side of the pivot, find nearest miss.
  always_comb begin
    piv_in  = (32'(bus.i_pivot) >= W) ? PW'(W - 1) : bus.i_pivot;
    chunk   = x_r[c_r*CHUNK_W +: CHUNK_W];
    piv_c   = CPW'(32'(piv_r) / CHUNK_W);
    off     = 32'(piv_r) % CHUNK_W;
    exam    = '1;
    hit_j   = 0;
    for (int unsigned j = 0; j < CHUNK_W; j++) begin
      if (c_r == piv_c) begin
        exam[j] = lsb_r ? (j <= off) : (j >= off);
      end
    end
    mm      = (chunk ^ {CHUNK_W{bit_r}}) & exam;
    hit_any = |mm;
    if (lsb_r) begin
      for (int unsigned j = 0; j < CHUNK_W; j++) begin
        if (mm[j]) hit_j = j;
      end
    end else begin
      for (int unsigned j = CHUNK_W; j > 0; j--) begin
        if (mm[j-1]) hit_j = j - 1;
      end
    end
    hit_pos = PW'(c_r*CHUNK_W + hit_j);
    last_c  = lsb_r ? (c_r == '0) : (c_r == CPW'(NCHUNK - 1));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state      <= IDLE;
      x_r        <= '0;
      piv_r      <= '0;
      bit_r      <= 1'b0;
      lsb_r      <= 1'b0;
      c_r        <= '0;
      bus.o_vld  <= 1'b0;
      bus.o_all  <= 1'b0;
      bus.o_pos  <= '0;
      bus.o_busy <= 1'b0;
    end else if (state != IDLE && bus.i_kill) begin
      state      <= IDLE;
      bus.o_vld  <= 1'b0;
      bus.o_all  <= 1'b0;
      bus.o_pos  <= '0;
      bus.o_busy <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (hit_any) begin
            state     <= DONE;
            bus.o_vld <= 1'b1;
            bus.o_all <= 1'b0;
            bus.o_pos <= hit_pos;
          end else if (last_c) begin
            state     <= DONE;
            bus.o_vld <= 1'b1;
            bus.o_all <= 1'b1;
            bus.o_pos <= '0;
          end else begin
            c_r <= lsb_r ? c_r - CPW'(1) : c_r + CPW'(1);
          end
        end
        DONE: begin
          if (bus.i_rdy) begin
            state      <= IDLE;
            bus.o_vld  <= 1'b0;
            bus.o_all  <= 1'b0;
            bus.o_pos  <= '0;
            bus.o_busy <= 1'b0;
          end
        end
        default: ;
      endcase
      // Back-to-back accept from DONE overrides the return to IDLE above.
      if (accept) begin
        state      <= SCAN;
        x_r        <= bus.i_x;
        piv_r      <= piv_in;
        bit_r      <= bus.i_bit;
        lsb_r      <= bus.i_lsb;
        c_r        <= CPW'(32'(piv_in) / CHUNK_W);
        bus.o_vld  <= 1'b0;
        bus.o_all  <= 1'b0;
        bus.o_pos  <= '0;
        bus.o_busy <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_u_mask_scan.sv
// Directed and randomized checks of u_mask_scan against a bit-level scan model.
module tb_u_mask_scan;
  localparam int unsigned W   = 64;
  localparam int unsigned CH  = 16;
  localparam int unsigned NCH = W / CH;

  logic clk = 1'b0;
  logic arst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  u_mask_scan_if #(.W(W)) bus ();
  u_mask_scan #(.W(W), .CHUNK_W(CH)) dut (.clk(clk), .arst(arst), .bus(bus));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walk bit by bit from the pivot; k counts the chunks touched.
  function automatic void model(input logic [W-1:0] x, input int piv, input logic b,
                                input logic lsb, output logic a, output int pos, output int k);
    int p;
    p   = (piv >= int'(W)) ? int'(W) - 1 : piv;
    a   = 1'b1;
    pos = 0;
    if (lsb) begin
      for (int i = p; i >= 0; i--) if (a && x[i] !== b) begin a = 1'b0; pos = i; end
      k = a ? p / int'(CH) + 1 : p / int'(CH) - pos / int'(CH) + 1;
    end else begin
      for (int i = p; i < int'(W); i++) if (a && x[i] !== b) begin a = 1'b0; pos = i; end
      k = a ? int'(NCH) - p / int'(CH) : pos / int'(CH) - p / int'(CH) + 1;
    end
  endfunction

  task automatic drive(input logic [W-1:0] x, input int piv, input logic b, input logic lsb);
    bus.i_x     = x;
    bus.i_pivot = 6'(piv);
    bus.i_bit   = b;
    bus.i_lsb   = lsb;
    bus.i_vld   = 1'b1;
  endtask

  // Issue from IDLE; returns #1 after the accepting edge.
  task automatic start_req(input logic [W-1:0] x, input int piv, input logic b, input logic lsb);
    @(negedge clk);
    drive(x, piv, b, lsb);
    @(posedge clk); #1;
    bus.i_vld = 1'b0;
  endtask

  // Called #1 after the accepting edge; cycles counted from the accepting cycle.
  task automatic wait_result(input string tag, input logic [W-1:0] x, input int piv,
                             input logic b, input logic lsb);
    logic e_all;
    int   e_pos, e_k, cnt;
    model(x, piv, b, lsb, e_all, e_pos, e_k);
    cnt = 1;
    while (bus.o_vld !== 1'b1 && cnt < 64) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'(e_k + 1));
    check({tag, "_all"}, 64'(bus.o_all), 64'(e_all));
    check({tag, "_pos"}, 64'(bus.o_pos), 64'(e_pos));
  endtask

  task automatic retire(input string tag);
    @(negedge clk);
    bus.i_rdy = 1'b1;
    @(posedge clk); #1;
    bus.i_rdy = 1'b0;
    check({tag, "_vld_clr"}, 64'(bus.o_vld), 64'd0);
    check({tag, "_idle"}, 64'(bus.o_busy), 64'd0);
  endtask

  logic [W-1:0] x, xn;
  logic         b, lsb, bn, lsbn, s_all;
  int           piv, pivn, r;
  logic [5:0]   s_pos;

  initial begin
    bus.i_vld = 1'b0; bus.i_x = '0; bus.i_pivot = '0; bus.i_bit = 1'b0;
    bus.i_lsb = 1'b0; bus.i_kill = 1'b0; bus.i_rdy = 1'b0;
    #2;
    check("rst_vld", 64'(bus.o_vld), 64'd0);
    check("rst_all", 64'(bus.o_all), 64'd0);
    check("rst_pos", 64'(bus.o_pos), 64'd0);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_rdy_held", 64'(bus.o_rdy), 64'd0);
    @(negedge clk); arst = 1'b0; #1;
    check("rst_rdy", 64'(bus.o_rdy), 64'd1);

    // Directed cases from the scan rules
    start_req('1, 63, 1'b1, 1'b1);                          wait_result("t1", '1, 63, 1'b1, 1'b1); retire("t1");
    x = 64'h0000_0000_0001_0000;
    start_req(x, 40, 1'b0, 1'b1);                           wait_result("t2", x, 40, 1'b0, 1'b1); retire("t2");
    x = ~((64'h1 << 5) | (64'h1 << 60));
    start_req(x, 5, 1'b1, 1'b0);                            wait_result("t3", x, 5, 1'b1, 1'b0); retire("t3");
    x = 64'hFFFF_FFFF_FFFF_FFFE;
    start_req(x, 0, 1'b1, 1'b1);                            wait_result("t6a", x, 0, 1'b1, 1'b1); retire("t6a");
    x = 64'h1;
    start_req(x, 0, 1'b1, 1'b1);                            wait_result("t6b", x, 0, 1'b1, 1'b1); retire("t6b");
    x = 64'h3FFFF;
    start_req(x, 17, 1'b1, 1'b1);                           wait_result("t6c", x, 17, 1'b1, 1'b1); retire("t6c");
    x = 64'h7FFF_FFFF_FFFF_FFFF;
    start_req(x, 63, 1'b0, 1'b0);                           wait_result("msb63", x, 63, 1'b0, 1'b0); retire("msb63");
    x = 64'h0000_0000_0000_0000;
    start_req(x, 32, 1'b0, 1'b0);                           wait_result("msb_all", x, 32, 1'b0, 1'b0); retire("msb_all");

    // Stalled result stays put, then retires with a same-edge new accept
    x = 64'h0000_0000_0001_0000;
    start_req(x, 40, 1'b0, 1'b1);                           wait_result("t4", x, 40, 1'b0, 1'b1);
    s_all = bus.o_all; s_pos = bus.o_pos;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t4_hold_vld", 64'(bus.o_vld), 64'd1);
      check("t4_hold_all", 64'(bus.o_all), 64'(s_all));
      check("t4_hold_pos", 64'(bus.o_pos), 64'(s_pos));
      check("t4_hold_rdy", 64'(bus.o_rdy), 64'd0);
    end
    @(negedge clk);
    bus.i_rdy = 1'b1; drive('1, 63, 1'b1, 1'b1); #1;
    check("t4_rdy_pass", 64'(bus.o_rdy), 64'd1);
    @(posedge clk); #1;
    bus.i_rdy = 1'b0; bus.i_vld = 1'b0;
    check("t4_b2b_vld", 64'(bus.o_vld), 64'd0);
    check("t4_b2b_busy", 64'(bus.o_busy), 64'd1);
    wait_result("t4b", '1, 63, 1'b1, 1'b1); retire("t4b");

    // Kill on scan cycle 2
    start_req('1, 63, 1'b1, 1'b1);
    @(posedge clk); #1;
    bus.i_kill = 1'b1;
    @(posedge clk); #1;
    bus.i_kill = 1'b0;
    check("t5_kill_busy", 64'(bus.o_busy), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("t5_kill_novld", 64'(bus.o_vld), 64'd0);
      @(posedge clk); #1;
    end

    // Reset mid-scan
    start_req('1, 63, 1'b1, 1'b1);
    @(posedge clk); #1;
    arst = 1'b1; #1;
    check("t5_rst_vld", 64'(bus.o_vld), 64'd0);
    check("t5_rst_busy", 64'(bus.o_busy), 64'd0);
    check("t5_rst_all", 64'(bus.o_all), 64'd0);
    check("t5_rst_pos", 64'(bus.o_pos), 64'd0);
    check("t5_rst_rdy", 64'(bus.o_rdy), 64'd0);
    @(negedge clk); arst = 1'b0; #1;
    check("t5_rst_rdy_up", 64'(bus.o_rdy), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("t5_rst_novld", 64'(bus.o_vld), 64'd0);
    end

    // Kill in DONE blocks a same-cycle request
    x = 64'h0000_0000_0001_0000;
    start_req(x, 40, 1'b0, 1'b1);                           wait_result("kd", x, 40, 1'b0, 1'b1);
    @(negedge clk);
    bus.i_kill = 1'b1; bus.i_rdy = 1'b1; drive('1, 63, 1'b1, 1'b1); #1;
    check("kd_rdy", 64'(bus.o_rdy), 64'd0);
    @(posedge clk); #1;
    bus.i_kill = 1'b0; bus.i_rdy = 1'b0; bus.i_vld = 1'b0;
    check("kd_busy", 64'(bus.o_busy), 64'd0);
    check("kd_vld", 64'(bus.o_vld), 64'd0);

    // Kill is ignored in IDLE
    @(negedge clk);
    bus.i_kill = 1'b1; drive(64'h0, 10, 1'b1, 1'b0);
    @(posedge clk); #1;
    bus.i_kill = 1'b0; bus.i_vld = 1'b0;
    wait_result("kidle", 64'h0, 10, 1'b1, 1'b0); retire("kidle");

    // Randomized chain, each result retired together with the next accept
    b = 1'b0; lsb = 1'b1; piv = 0; x = '1;
    start_req(x, piv, b, lsb);
    for (int n = 0; n < 60; n++) begin
      wait_result("rnd", x, piv, b, lsb);
      bn = 1'($urandom); lsbn = 1'($urandom); pivn = int'($urandom_range(0, W - 1));
      r  = int'($urandom_range(0, 3));
      xn = {W{bn}};
      if (r == 0) xn = {$urandom, $urandom};
      if (r >= 2) xn[$urandom_range(0, W - 1)] = ~bn;
      if (r == 3) xn[$urandom_range(0, W - 1)] = ~bn;
      @(negedge clk);
      bus.i_rdy = 1'b1; drive(xn, pivn, bn, lsbn);
      @(posedge clk); #1;
      bus.i_rdy = 1'b0; bus.i_vld = 1'b0;
      x = xn; piv = pivn; b = bn; lsb = lsbn;
    end
    wait_result("rnd", x, piv, b, lsb); retire("rnd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
